// File: rtl/fir_result_reader_if.sv
// ----------------------------------------------------------------------------
// fir_result_reader_if
//
// Purpose: valid/ready stream carrying scaled FIR results out of the
// result reader.
//
// Signals:
//   m_data   - scaled result word (OUT_W bits)
//   m_valid  - m_data holds a word
//   m_ready  - downstream accepts the word on this clock
//   m_last   - final word of the transfer, qualified by m_valid
//
// Modports:
//   master - the producer (fir_result_reader)
//   slave  - the consumer
// ----------------------------------------------------------------------------
interface fir_result_reader_if #(
    parameter int OUT_W = 32
);
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fir_result_reader.sv
// ----------------------------------------------------------------------------
// fir_result_reader
//
// Purpose: walks len consecutive addresses of the FIR output RAM starting at
// base, scales each signed DATA_W-bit accumulation down to OUT_W bits and
// streams it out on a valid/ready interface with a last-beat flag.  A 2-entry
// buffer keeps one word per clock flowing under continuous m_ready and
// absorbs arbitrary backpressure.
//
// Ports:
//   clk            - rising-edge clock
//   rst            - asynchronous, active-low reset
//   start          - begin a transfer (only looked at while idle)
//   base           - first RAM address, captured with start
//   len            - word count 0..2^ADDR_W, captured with start
//   output_read_en - registered RAM read strobe
//   output_address - registered RAM read address (wraps modulo 2^ADDR_W)
//   ram_data       - RAM read data, valid the cycle after output_read_en
//   m_if           - result stream (master side)
//   busy           - transfer in progress
//   done           - one-cycle completion pulse
//
// Build option:
//   FIR_RESULT_SAT_EN - when defined, the shifted result saturates to the
//                       signed OUT_W range; otherwise it is truncated to its
//                       low OUT_W bits.
// ----------------------------------------------------------------------------
module fir_result_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 93,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W:0]       len,
    output logic                  output_read_en,
    output logic [ADDR_W-1:0]     output_address,
    input  logic [DATA_W-1:0]     ram_data,
    fir_result_reader_if.master   m_if,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    state_t                  state;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W:0]         len_q;
    logic [ADDR_W:0]         issue_cnt;
    logic [ADDR_W:0]         accept_cnt;
    logic                    ram_valid;

    logic [OUT_W-1:0]        fifo_mem [0:1];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_cnt;
    logic [1:0]              fifo_cnt_next;

    logic signed [DATA_W-1:0] shifted;
    logic [OUT_W-1:0]        scaled;

    logic                    fifo_empty;
    logic                    stream_valid;
    logic [OUT_W-1:0]        stream_data;
    logic                    handshake;
    logic                    push;
    logic                    pop;
    logic                    is_last;
    logic                    can_issue;

    // Scale the returning RAM word: arithmetic shift first, then either clamp
    // to the signed OUT_W range or keep the low bits.  The clamp test asks
    // whether every bit from the OUT_W sign position upward agrees.
    always_comb begin
        shifted = $signed(ram_data) >>> SHIFT;
`ifdef FIR_RESULT_SAT_EN
        if ((&shifted[DATA_W-1:OUT_W-1]) || !(|shifted[DATA_W-1:OUT_W-1])) begin
            scaled = shifted[OUT_W-1:0];
        end else if (shifted[DATA_W-1]) begin
            scaled = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            scaled = {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        scaled = shifted[OUT_W-1:0];
`endif
    end

`ifndef FIR_RESULT_SAT_EN
    logic scale_unused;
    assign scale_unused = ^shifted[DATA_W-1:OUT_W];
`endif

    // Stream side.  When the buffer is empty the word arriving from the RAM
    // is presented directly (fall-through), which gives the two-clock
    // start-to-valid latency; if it is not taken it is written into the
    // buffer and reappears unchanged at the head on the next cycle.
    // A new read is issued only if, after this edge, buffered words plus the
    // strobe already out plus the new strobe stay within the two slots.
    always_comb begin
        fifo_empty    = (fifo_cnt == 2'd0);
        stream_valid  = !fifo_empty || ram_valid;
        if (!fifo_empty) begin
            stream_data = fifo_mem[rd_ptr];
        end else if (ram_valid) begin
            stream_data = scaled;
        end else begin
            stream_data = '0;
        end
        handshake     = stream_valid && m_if.m_ready;
        push          = ram_valid && !(fifo_empty && m_if.m_ready);
        pop           = !fifo_empty && m_if.m_ready;
        fifo_cnt_next = fifo_cnt + {1'b0, push} - {1'b0, pop};
        is_last       = (accept_cnt == (len_q - ONE));
        can_issue     = (issue_cnt < len_q) &&
                        (({1'b0, fifo_cnt_next} + {2'b00, output_read_en}) < 3'd2);
    end

    assign m_if.m_valid = stream_valid;
    assign m_if.m_data  = stream_data;
    assign m_if.m_last  = stream_valid && is_last;

    // Control FSM, read issue, buffer and counters.  Reset drops everything,
    // including the marker for a read in flight, so stale RAM data returning
    // after reset is never captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            base_q         <= '0;
            len_q          <= '0;
            issue_cnt      <= '0;
            accept_cnt     <= '0;
            ram_valid      <= 1'b0;
            fifo_mem[0]    <= '0;
            fifo_mem[1]    <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_cnt       <= 2'd0;
            output_read_en <= 1'b0;
            output_address <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ram_valid <= output_read_en;

            if (push) begin
                fifo_mem[wr_ptr] <= scaled;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt_next;

            if (handshake) begin
                accept_cnt <= accept_cnt + ONE;
            end

            case (state)
                IDLE: begin
                    output_read_en <= 1'b0;
                    done           <= 1'b0;
                    issue_cnt      <= '0;
                    accept_cnt     <= '0;
                    if (start) begin
                        base_q <= base;
                        len_q  <= len;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            // First read goes out straight away so the
                            // strobe appears the cycle after start.
                            state          <= RUN;
                            busy           <= 1'b1;
                            output_read_en <= 1'b1;
                            output_address <= base;
                            issue_cnt      <= ONE;
                        end
                    end
                end

                RUN: begin
                    if (can_issue) begin
                        output_read_en <= 1'b1;
                        output_address <= base_q + issue_cnt[ADDR_W-1:0];
                        issue_cnt      <= issue_cnt + ONE;
                    end else begin
                        output_read_en <= 1'b0;
                    end
                    if (handshake && is_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                FIN: begin
                    output_read_en <= 1'b0;
                    done           <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    output_read_en <= 1'b0;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_result_reader.sv
// ----------------------------------------------------------------------------
// tb_fir_result_reader
//
// Purpose: directed self-checking bench for fir_result_reader.  A behavioural
// RAM answers reads one cycle after the strobe; RAM[a] holds a << 40 plus
// small low-order noise, so the expected stream word for address a is a.
// ----------------------------------------------------------------------------
module tb_fir_result_reader;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 93;
    localparam int OUT_W  = 32;
    localparam int SHIFT  = 40;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base = '0;
    logic [ADDR_W:0]     len = '0;
    logic                output_read_en;
    logic [ADDR_W-1:0]   output_address;
    logic [DATA_W-1:0]   ram_data = '0;
    logic                busy;
    logic                done;

    fir_result_reader_if #(.OUT_W(OUT_W)) stream ();

    fir_result_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base           (base),
        .len            (len),
        .output_read_en (output_read_en),
        .output_address (output_address),
        .ram_data       (ram_data),
        .m_if           (stream),
        .busy           (busy),
        .done           (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural synchronous-read RAM.
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (output_read_en) begin
            ram_data <= ram[output_address];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    logic [OUT_W-1:0]  beat_data[$];
    logic              beat_last[$];
    int                beat_cyc[$];
    logic [ADDR_W-1:0] strobe_addr[$];
    logic [OUT_W-1:0]  exp_data[$];
    int                done_at;
    int                done_cnt;
    int                first_valid;
    int                max_out;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Runs one transfer: pulses start, then observes every cycle (index 1 is
    // the cycle after the start edge) until two cycles past done.
    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                                 input int ready_pct, input int glitch_cyc);
        int               hs;
        int               out_now;
        logic             prev_valid;
        logic             prev_ready;
        logic             prev_last;
        logic [OUT_W-1:0] prev_data;
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        strobe_addr.delete();
        done_at     = -1;
        done_cnt    = 0;
        first_valid = -1;
        max_out     = 0;
        hs          = 0;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        prev_last   = 1'b0;
        prev_data   = '0;
        base  = b;
        len   = n;
        start = 1'b1;
        stream.m_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == glitch_cyc) begin
                start = 1'b1;
                base  = 11'd5;
                len   = 12'd1;
            end else begin
                start = 1'b0;
            end
            stream.m_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (prev_valid && !prev_ready) begin
                checkOutput("stall_hold", {stream.m_valid, stream.m_last, stream.m_data},
                            {1'b1, prev_last, prev_data});
            end
            if (output_read_en) strobe_addr.push_back(output_address);
            out_now = strobe_addr.size() - hs;
            if (out_now > max_out) max_out = out_now;
            if (stream.m_valid && first_valid < 0) first_valid = cyc;
            if (stream.m_valid && stream.m_ready) begin
                beat_data.push_back(stream.m_data);
                beat_last.push_back(stream.m_last);
                beat_cyc.push_back(cyc);
                hs++;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            prev_valid = stream.m_valid;
            prev_ready = stream.m_ready;
            prev_last  = stream.m_last;
            prev_data  = stream.m_data;
            if (done_at >= 0 && cyc >= done_at + 2) break;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stream.m_ready = 1'b0;
        if (done_at < 0) checkOutput("timeout_done", 1'b0, 1'b1);
    endtask

    // Compares the recorded transfer against exp_data and the address walk.
    task automatic checkTransfer(input string tag, input logic [ADDR_W-1:0] b,
                                 input logic [ADDR_W:0] n);
        logic [ADDR_W-1:0] ea;
        checkOutput({tag, "_beats"}, beat_data.size(), n);
        checkOutput({tag, "_strobes"}, strobe_addr.size(), n);
        for (int i = 0; i < beat_data.size() && i < exp_data.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), beat_data[i], exp_data[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), beat_last[i], (i == int'(n) - 1));
        end
        for (int i = 0; i < strobe_addr.size(); i++) begin
            ea = b + ADDR_W'(i);
            checkOutput($sformatf("%s_addr%0d", tag, i), strobe_addr[i], ea);
        end
        checkOutput({tag, "_done_pulse"}, done_cnt, 1);
        checkOutput({tag, "_outstanding_le2"}, (max_out <= 2), 1'b1);
    endtask

    task automatic fillExpected(input logic [ADDR_W-1:0] b, input int n);
        exp_data.delete();
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(OUT_W'((int'(b) + i) % DEPTH));
        end
    endtask

    initial begin
        int hs;
        for (int a = 0; a < DEPTH; a++) begin
            ram[a] = (DATA_W'(a) << SHIFT) | DATA_W'(a * 13 + 7);
        end
        stream.m_ready = 1'b0;

        // Reset values.
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {output_read_en, output_address, stream.m_valid, stream.m_data,
                     stream.m_last, busy, done}, 48'd0);
        rst = 1'b1;

        // Basic transfer with full throughput.
        applyStimulus(11'd0, 12'd4, 100, 0);
        fillExpected(11'd0, 4);
        checkTransfer("basic", 11'd0, 12'd4);
        checkOutput("basic_first_valid", first_valid, 2);
        checkOutput("basic_done_at", done_at, 6);
        for (int i = 0; i < beat_cyc.size(); i++) begin
            checkOutput($sformatf("basic_beat_cyc%0d", i), beat_cyc[i], 2 + i);
        end

        // Random backpressure.
        applyStimulus(11'd300, 12'd16, 50, 0);
        fillExpected(11'd300, 16);
        checkTransfer("bp", 11'd300, 12'd16);

        // Address wrap at the top of the RAM.
        applyStimulus(11'd2046, 12'd4, 100, 0);
        fillExpected(11'd2046, 4);
        checkTransfer("wrap", 11'd2046, 12'd4);

        // Out-of-range results and a negative value that rounds down.
        ram[100] = DATA_W'(1) << 80;
        ram[101] = -(DATA_W'(1) << 80);
        ram[102] = -(DATA_W'(5) << 40) - DATA_W'(1);
        applyStimulus(11'd100, 12'd3, 100, 0);
        exp_data.delete();
`ifdef FIR_RESULT_SAT_EN
        exp_data.push_back(32'h7FFF_FFFF);
        exp_data.push_back(32'h8000_0000);
`else
        exp_data.push_back(32'h0000_0000);
        exp_data.push_back(32'h0000_0000);
`endif
        exp_data.push_back(32'hFFFF_FFFA);
        checkTransfer("ovf", 11'd100, 12'd3);

        // Zero-length transfer.
        applyStimulus(11'd0, 12'd0, 100, 0);
        checkOutput("len0_done_at", done_at, 1);
        checkOutput("len0_strobes", strobe_addr.size(), 0);
        checkOutput("len0_valid", first_valid, -1);
        checkOutput("len0_done_pulse", done_cnt, 1);

        // start pulsed mid-transfer is ignored.
        applyStimulus(11'd700, 12'd6, 100, 3);
        fillExpected(11'd700, 6);
        checkTransfer("glitch", 11'd700, 12'd6);

        // Reset after three of eight beats.
        base  = 11'd10;
        len   = 12'd8;
        start = 1'b1;
        stream.m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hs = 0;
        for (int c = 0; c < 40 && hs < 3; c++) begin
            if (stream.m_valid && stream.m_ready) hs++;
            if (hs < 3) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("rstmid_three_beats", hs, 3);
        @(posedge clk);
        #1;
        checkOutput("rstmid_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_outputs_now",
                    {output_read_en, output_address, stream.m_valid, stream.m_data,
                     stream.m_last, busy, done}, 48'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rstmid_outputs_held",
                    {output_read_en, output_address, stream.m_valid, stream.m_data,
                     stream.m_last, busy, done}, 48'd0);
        rst = 1'b1;
        stream.m_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(11'd500, 12'd2, 100, 0);
        fillExpected(11'd500, 2);
        checkTransfer("after_rst", 11'd500, 12'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
